// File: rtl/mem_arbiter_pkg.sv
// Purpose: shared types and constants for the fetch/data memory arbiter.
// Latency: none (declarations and a pure combinational helper only).
// Backpressure: n/a.
// Contents: FSM state encoding, port-select constants, latched request
// record, and the round-robin pick helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] dtw;
    } mem_req_t;

    // Round-robin pick between the two ports. On a tie the port that was
    // not served last wins; otherwise whichever port is requesting.
    function automatic logic pick_port(input logic f_req,
                                       input logic d_req,
                                       input logic last);
        if (f_req && d_req) begin
            return ~last;
        end else if (d_req) begin
            return PORT_D;
        end
        return PORT_F;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_req_latch.sv
// Purpose: per-port request holder (pending flag plus latched addr/rw/dtw).
// Latency: capture on the stb edge; the live inputs are also forwarded in that
// cycle so the arbiter can issue without waiting for the latch.
// Backpressure: stb is ignored while a request is pending or in flight.
//
// Ports:
//   clk, reset            clock, async active-low reset
//   stb, rw, addr, dtw    incoming request from the port
//   done                  arbiter finished this port's request (clears pending)
//   req_vld               a request is pending or arriving this cycle
//   req_rw/addr/dtw       the request to issue (latched, or live if new)
module arb_req_latch
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stb,
    input  logic        rw,
    input  logic [31:0] addr,
    input  logic [31:0] dtw,
    input  logic        done,
    output logic        req_vld,
    output logic        req_rw,
    output logic [31:0] req_addr,
    output logic [31:0] req_dtw
);

    logic     pend;
    mem_req_t held;
    mem_req_t live;

    assign live = '{rw: rw, addr: addr, dtw: dtw};

    // done can only arrive while pend is set, and capture needs pend clear,
    // so the two never compete for the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= 1'b0;
            held <= '0;
        end else begin
            if (done) begin
                pend <= 1'b0;
            end else if (stb && !pend) begin
                pend <= 1'b1;
                held <= live;
            end
        end
    end

    // A fresh stb is visible immediately so the arbiter can grant it on the
    // same edge that latches it.
    assign req_vld  = pend | stb;
    assign req_rw   = pend ? held.rw   : live.rw;
    assign req_addr = pend ? held.addr : live.addr;
    assign req_dtw  = pend ? held.dtw  : live.dtw;

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: round-robin arbiter merging a read-only fetch port and a data port onto one SRAM port.
// Latency: stb edge -> m_stb next cycle; m_ack -> port ack next cycle (all outputs registered).
// Backpressure: one outstanding request per port (extra stb dropped); waits on m_ack, or aborts with err after TIMEOUT_CYC when MEM_ARB_TIMEOUT_EN is defined.
//
// Ports:
//   clk, reset                          clock, async active-low reset
//   f_stb, f_addr -> f_ack, f_dtr, f_err        fetch port (reads only)
//   d_stb, d_rw, d_addr, d_dtw -> d_ack, d_dtr, d_err   data port (d_rw=1 write)
//   m_stb, m_rw, m_addr, m_dtw <- m_ack, m_dtr  downstream SRAM controller
// Build option: MEM_ARB_TIMEOUT_EN enables the abort timer; without it the
// err outputs are tied low and TIMEOUT_CYC has no effect.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_stb,
    input  logic [31:0] f_addr,
    output logic        f_ack,
    output logic [31:0] f_dtr,
    output logic        f_err,
    input  logic        d_stb,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_dtw,
    output logic        d_ack,
    output logic [31:0] d_dtr,
    output logic        d_err,
    output logic        m_stb,
    output logic        m_rw,
    output logic [31:0] m_addr,
    output logic [31:0] m_dtw,
    input  logic        m_ack,
    input  logic [31:0] m_dtr
);

    arb_state_t  state;
    arb_state_t  state_nxt;
    logic        grant;
    logic        last;

    logic        f_vld, f_req_rw;
    logic [31:0] f_req_addr, f_req_dtw;
    logic        d_vld, d_req_rw;
    logic [31:0] d_req_addr, d_req_dtw;

    logic        start;
    logic        sel;
    logic        m_ack_hit;
    logic        timeout_hit;
    logic        done;
    logic        f_done;
    logic        d_done;

    // Fetch never writes: rw and write data are tied low at its latch, so the
    // common mux below yields m_rw=0 / m_dtw=0 for fetch grants.
    arb_req_latch u_f_latch (
        .clk      (clk),
        .reset    (reset),
        .stb      (f_stb),
        .rw       (1'b0),
        .addr     (f_addr),
        .dtw      (32'h0),
        .done     (f_done),
        .req_vld  (f_vld),
        .req_rw   (f_req_rw),
        .req_addr (f_req_addr),
        .req_dtw  (f_req_dtw)
    );

    arb_req_latch u_d_latch (
        .clk      (clk),
        .reset    (reset),
        .stb      (d_stb),
        .rw       (d_rw),
        .addr     (d_addr),
        .dtw      (d_dtw),
        .done     (d_done),
        .req_vld  (d_vld),
        .req_rw   (d_req_rw),
        .req_addr (d_req_addr),
        .req_dtw  (d_req_dtw)
    );

    assign start     = (state == IDLE) && (f_vld || d_vld);
    assign sel       = pick_port(f_vld, d_vld, last);
    // m_ack only counts while a transaction is on the bus.
    assign m_ack_hit = ((state == ISSUE) || (state == WAIT)) && m_ack;
    assign done      = m_ack_hit || timeout_hit;
    assign f_done    = done && (grant == PORT_F);
    assign d_done    = done && (grant == PORT_D);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (f_vld || d_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = done ? IDLE : WAIT;
            WAIT:    if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            grant  <= PORT_F;
            last   <= PORT_F;
            m_stb  <= 1'b0;
            m_rw   <= 1'b0;
            m_addr <= '0;
            m_dtw  <= '0;
            f_ack  <= 1'b0;
            d_ack  <= 1'b0;
            f_dtr  <= '0;
            d_dtr  <= '0;
        end else begin
            state <= state_nxt;
            // m_stb is high only for the ISSUE cycle that follows a grant.
            m_stb <= start;
            f_ack <= f_done;
            d_ack <= d_done;
            // Bus fields load only at grant and hold through completion.
            if (start) begin
                grant  <= sel;
                last   <= sel;
                m_rw   <= (sel == PORT_D) ? d_req_rw   : f_req_rw;
                m_addr <= (sel == PORT_D) ? d_req_addr : f_req_addr;
                m_dtw  <= (sel == PORT_D) ? d_req_dtw  : f_req_dtw;
            end
            // A real m_ack beats a simultaneous timeout; an abort returns zero.
            if (f_done) f_dtr <= m_ack_hit ? m_dtr : '0;
            if (d_done) d_dtr <= m_ack_hit ? m_dtr : '0;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] to_cnt;

    // Counts cycles spent in ISSUE/WAIT; zero during the ISSUE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (state == IDLE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state != IDLE) && !m_ack &&
                         (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_err <= 1'b0;
            d_err <= 1'b0;
        end else begin
            f_err <= timeout_hit && (grant == PORT_F);
            d_err <= timeout_hit && (grant == PORT_D);
        end
    end
`else
    logic [31:0] unused_timeout_cyc;

    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
    assign timeout_hit        = 1'b0;
    assign f_err              = 1'b0;
    assign d_err              = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter against a transaction-level model.
// Latency: model predicts registered outputs one edge after the inputs that cause them.
// Backpressure: bench memory responder answers m_stb after 0..2 extra cycles.
`timescale 1ns/1ps
module tb_mem_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TB_TO = 4;
`else
    localparam int TB_TO = 64;
`endif

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        f_stb  = 1'b0;
    logic [31:0] f_addr = '0;
    logic        d_stb  = 1'b0;
    logic        d_rw   = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_dtw  = '0;
    logic        m_ack  = 1'b0;
    logic [31:0] m_dtr  = '0;

    logic        f_ack, f_err, d_ack, d_err, m_stb, m_rw;
    logic [31:0] f_dtr, d_dtr, m_addr, m_dtw;

    mem_arbiter #(.TIMEOUT_CYC(TB_TO)) dut (
        .clk    (clk),
        .reset  (reset),
        .f_stb  (f_stb),
        .f_addr (f_addr),
        .f_ack  (f_ack),
        .f_dtr  (f_dtr),
        .f_err  (f_err),
        .d_stb  (d_stb),
        .d_rw   (d_rw),
        .d_addr (d_addr),
        .d_dtw  (d_dtw),
        .d_ack  (d_ack),
        .d_dtr  (d_dtr),
        .d_err  (d_err),
        .m_stb  (m_stb),
        .m_rw   (m_rw),
        .m_addr (m_addr),
        .m_dtw  (m_dtw),
        .m_ack  (m_ack),
        .m_dtr  (m_dtr)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model: index 0 = fetch, 1 = data.
    bit          mp_pend [2];
    bit          mp_rw   [2];
    logic [31:0] mp_addr [2];
    logic [31:0] mp_dtw  [2];
    bit          m_busy;
    int          m_gnt;
    int          m_last;
    int          m_age;
    bit          e_m_stb, e_m_rw;
    logic [31:0] e_m_addr, e_m_dtw;
    bit          e_ack [2];
    bit          e_err [2];
    logic [31:0] e_dtr [2];

    // Responder state.
    bit auto_ack = 1'b0;
    bit r_out    = 1'b0;
    int r_dly    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            mp_pend[p] = 0; mp_rw[p] = 0; mp_addr[p] = '0; mp_dtw[p] = '0;
            e_ack[p] = 0; e_err[p] = 0; e_dtr[p] = '0;
        end
        m_busy = 0; m_gnt = 0; m_last = 0; m_age = 0;
        e_m_stb = 0; e_m_rw = 0; e_m_addr = '0; e_m_dtw = '0;
    endtask

    // Advance the model over one rising edge using the inputs held before it.
    task automatic model_step();
        bit          stb [2];
        bit          rw  [2];
        logic [31:0] a   [2];
        logic [31:0] w   [2];
        bit          was_busy, fin, tmo;
        int          g;
        stb[0] = f_stb; a[0] = f_addr; w[0] = '0;    rw[0] = 0;
        stb[1] = d_stb; a[1] = d_addr; w[1] = d_dtw; rw[1] = d_rw;
        e_ack[0] = 0; e_ack[1] = 0; e_err[0] = 0; e_err[1] = 0;
        e_m_stb = 0;
        was_busy = m_busy;
        fin = 0; tmo = 0;
        if (m_busy) begin
            if (m_ack) fin = 1;
`ifdef MEM_ARB_TIMEOUT_EN
            else if (m_age == TB_TO) begin fin = 1; tmo = 1; end
`endif
            else m_age++;
        end
        for (int p = 0; p < 2; p++) begin
            if (stb[p] && !mp_pend[p]) begin
                mp_pend[p] = 1; mp_addr[p] = a[p]; mp_dtw[p] = w[p]; mp_rw[p] = rw[p];
            end
        end
        if (fin) begin
            e_ack[m_gnt] = 1;
            e_err[m_gnt] = tmo;
            e_dtr[m_gnt] = tmo ? 32'h0 : m_dtr;
            mp_pend[m_gnt] = 0;
            m_busy = 0;
        end
        if (!was_busy && (mp_pend[0] || mp_pend[1])) begin
            if (mp_pend[0] && mp_pend[1]) g = 1 - m_last;
            else g = mp_pend[1] ? 1 : 0;
            m_busy = 1; m_age = 1; m_gnt = g; m_last = g;
            e_m_stb = 1; e_m_addr = mp_addr[g]; e_m_rw = mp_rw[g]; e_m_dtw = mp_dtw[g];
        end
    endtask

    task automatic compare_all();
        chk("m_stb",  m_stb,  e_m_stb);
        chk("m_rw",   m_rw,   e_m_rw);
        chk("m_addr", m_addr, e_m_addr);
        chk("m_dtw",  m_dtw,  e_m_dtw);
        chk("f_ack",  f_ack,  e_ack[0]);
        chk("d_ack",  d_ack,  e_ack[1]);
        chk("f_err",  f_err,  e_err[0]);
        chk("d_err",  d_err,  e_err[1]);
        chk("f_dtr",  f_dtr,  e_dtr[0]);
        chk("d_dtr",  d_dtr,  e_dtr[1]);
        chk("ack_excl", f_ack & d_ack, 1'b0);
    endtask

    task automatic responder();
        if (m_stb) begin r_out = 1; r_dly = $urandom_range(0, 2); end
        if (r_out) begin
            m_ack = (r_dly == 0);
            if (r_dly == 0) r_out = 0;
            else r_dly--;
        end else begin
            m_ack = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (auto_ack) responder();
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_m_stb", m_stb, 1'b0);
        chk("rst_m_rw", m_rw, 1'b0);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_m_dtw", m_dtw, 32'h0);
        chk("rst_f_ack", f_ack, 1'b0);
        chk("rst_d_ack", d_ack, 1'b0);
        chk("rst_f_err", f_err, 1'b0);
        chk("rst_d_err", d_err, 1'b0);
        chk("rst_f_dtr", f_dtr, 32'h0);
        chk("rst_d_dtr", d_dtr, 32'h0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Wait (bounded) for m_stb, note the address issued, then ack it.
    task automatic serve(output logic [31:0] a);
        int n = 0;
        while (m_stb !== 1'b1 && n < 20) begin cycle(); n++; end
        chk("serve_m_stb_seen", m_stb, 1'b1);
        a = m_addr;
        m_ack = 1'b1;
        cycle();
        m_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] g1, g2, gx;
        int n_stb;
        model_reset();
        do_reset();
        cycle();

        // Data write: issued the next cycle, acked one cycle after m_ack.
        d_stb = 1; d_rw = 1; d_addr = 32'hAAAA_AAA1; d_dtw = 32'hABCD_1234;
        cycle();
        d_stb = 0; d_rw = 0;
        chk("t_wr_m_stb", m_stb, 1'b1);
        chk("t_wr_m_rw", m_rw, 1'b1);
        chk("t_wr_m_addr", m_addr, 32'hAAAA_AAA1);
        chk("t_wr_m_dtw", m_dtw, 32'hABCD_1234);
        m_ack = 1; m_dtr = 32'h0BAD_F00D;
        cycle();
        m_ack = 0;
        chk("t_wr_d_ack", d_ack, 1'b1);
        chk("t_wr_f_ack", f_ack, 1'b0);
        cycle();
        chk("t_wr_d_ack_pulse", d_ack, 1'b0);

        // Fetch read returns m_dtr on f_dtr.
        f_stb = 1; f_addr = 32'h0000_0100;
        cycle();
        f_stb = 0;
        chk("t_rd_m_rw", m_rw, 1'b0);
        chk("t_rd_m_addr", m_addr, 32'h0000_0100);
        cycle();
        m_ack = 1; m_dtr = 32'h1234_ABCD;
        cycle();
        m_ack = 0;
        chk("t_rd_f_dtr", f_dtr, 32'h1234_ABCD);
        chk("t_rd_f_ack", f_ack, 1'b1);
        chk("t_rd_d_ack", d_ack, 1'b0);
        cycle();

        // Round robin: data first after reset, fetch first once data was last.
        do_reset();
        f_stb = 1; f_addr = 32'h0000_F001; d_stb = 1; d_addr = 32'h0000_D001;
        cycle();
        f_stb = 0; d_stb = 0;
        serve(g1);
        serve(g2);
        chk("t_rr_first_data", g1, 32'h0000_D001);
        chk("t_rr_second_fetch", g2, 32'h0000_F001);
        d_stb = 1; d_addr = 32'h0000_D002;
        cycle();
        d_stb = 0;
        serve(gx);
        f_stb = 1; f_addr = 32'h0000_F003; d_stb = 1; d_addr = 32'h0000_D003;
        cycle();
        f_stb = 0; d_stb = 0;
        serve(g1);
        serve(g2);
        chk("t_rr_repeat_fetch", g1, 32'h0000_F003);
        chk("t_rr_repeat_data", g2, 32'h0000_D003);
        cycle();

        // Second d_stb during an in-flight data request is dropped.
        n_stb = 0;
        d_stb = 1; d_addr = 32'h0000_2000; m_dtr = 32'hFFFF_0000;
        cycle(); n_stb += int'(m_stb);
        repeat (2) begin cycle(); n_stb += int'(m_stb); end
        d_stb = 0; m_ack = 1;
        cycle(); n_stb += int'(m_stb);
        m_ack = 0;
        repeat (3) begin cycle(); n_stb += int'(m_stb); end
        chk("t_busy_single_issue", n_stb, 1);
        chk("t_busy_d_dtr", d_dtr, 32'hFFFF_0000);

`ifdef MEM_ARB_TIMEOUT_EN
        // Missing m_ack aborts after TB_TO cycles with ack+err and zero data.
        d_stb = 1; d_addr = 32'h0000_3000; m_dtr = 32'hDEAD_BEEF;
        cycle();
        d_stb = 0;
        repeat (3) cycle();
        chk("t_to_not_yet", d_ack, 1'b0);
        cycle();
        chk("t_to_d_ack", d_ack, 1'b1);
        chk("t_to_d_err", d_err, 1'b1);
        chk("t_to_d_dtr", d_dtr, 32'h0);
        f_stb = 1; f_addr = 32'h0000_4000;
        cycle();
        f_stb = 0;
        chk("t_to_idle_reissue", m_stb, 1'b1);
        serve(gx);
        cycle();
`endif

        // Reset during WAIT clears outputs at once; a late m_ack gives no ack.
        d_stb = 1; d_rw = 1; d_addr = 32'h0000_5000; d_dtw = 32'h0000_0055;
        cycle();
        d_stb = 0; d_rw = 0;
        cycle();
        do_reset();
        m_ack = 1;
        cycle();
        m_ack = 0;
        cycle();
        chk("t_rst_late_d_ack", d_ack, 1'b0);
        chk("t_rst_late_f_ack", f_ack, 1'b0);
        cycle();

        // Randomized traffic against the model.
        auto_ack = 1; r_out = 0;
        repeat (1500) begin
            f_stb  = ($urandom_range(0, 2) == 0);
            d_stb  = ($urandom_range(0, 2) == 0);
            f_addr = $urandom;
            d_addr = $urandom;
            d_dtw  = $urandom;
            d_rw   = 1'($urandom_range(0, 1));
            m_dtr  = $urandom;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
